// File: rtl/program_memory.sv
// program_memory: single-clock instruction store with a byte-serial program loader.
// Optional PROGRAM_MEMORY_PARITY_EN adds a per-word even-parity bit checked on fetch.
module program_memory #(
    parameter int DATA_WIDTH = 28,
    parameter int ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    input  logic                  iLoadStart,
    input  logic [ADDR_WIDTH:0]   iLoadLength,
    input  logic [7:0]            iLoadByte,
    input  logic                  iLoadValid,
    output logic                  oLoadReady,
    output logic                  oLoadBusy,
    output logic                  oLoadDone,
    output logic                  oParityError
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BPW = (DATA_WIDTH + 7) / 8;
    localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [8*BPW-1:0]      shift_word;
    logic [ADDR_WIDTH:0]   ptr, len, len_in, ptr_next;
    logic [CW-1:0]         cnt;
    logic                  fetch_ok, last_byte;
    logic [DATA_WIDTH-1:0] wr_word;

    assign oLoadReady = state == RECV;
    assign oLoadBusy  = state == RECV || state == WRITE;
    assign oLoadDone  = state == DONE;
    assign len_in     = iLoadLength > DEPTH_L ? DEPTH_L : iLoadLength;
    assign ptr_next   = ptr + (ADDR_WIDTH + 1)'(1);
    assign last_byte  = cnt == CW'(BPW - 1);
    assign wr_word    = shift_word[DATA_WIDTH-1:0];
    assign fetch_ok   = 32'(iAddress) < DEPTH && !oLoadBusy;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            len   <= '0;
        end else begin
            case (state)
                IDLE: if (iLoadStart) begin
                    len   <= len_in;
                    ptr   <= '0;
                    cnt   <= '0;
                    state <= len_in == '0 ? DONE : RECV;
                end
                // Bytes arrive little-endian: each new byte enters at the top and slides down.
                RECV: if (iLoadValid) begin
                    shift_word <= (8*BPW)'({iLoadByte, shift_word} >> 8);
                    cnt        <= last_byte ? '0 : cnt + CW'(1);
                    state      <= last_byte ? WRITE : RECV;
                end
                WRITE: begin
                    ptr   <= ptr_next;
                    state <= ptr_next == len ? DONE : RECV;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately left out of reset so a program survives a reset.
    always_ff @(posedge Clock) begin
        if (!Reset && state == WRITE)
            mem[ptr[ADDR_WIDTH-1:0]] <= wr_word;
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            oInstruction <= DEFAULT_WORD;
        else
            oInstruction <= fetch_ok ? mem[iAddress[ADDR_WIDTH-1:0]] : DEFAULT_WORD;
    end

`ifdef PROGRAM_MEMORY_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (!Reset && state == WRITE)
            par_mem[ptr[ADDR_WIDTH-1:0]] <= ^wr_word;
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            oParityError <= 1'b0;
        else
            oParityError <= fetch_ok &&
                (^mem[iAddress[ADDR_WIDTH-1:0]] != par_mem[iAddress[ADDR_WIDTH-1:0]]);
    end
`else
    assign oParityError = 1'b0;
`endif
endmodule
